// File: rtl/ahb_slave_ws_mem.sv
// ---------------------------------------------------------------------------
// ahb_slave_ws_mem
//
// AHB-Lite slave backed by an internal word-organised memory. Every OKAY
// transfer is stretched by a fixed number of wait states; illegal transfers
// (out of range, unsupported size, misaligned) get the two-cycle ERROR
// response and never touch memory.
//
// Parameters
//   MEM_DEPTH    number of 32-bit words (power of two, 4..4096)
//   WAIT_STATES  wait cycles inserted before each OKAY data phase (0..15)
//   BASE_ADDR    byte address of word 0, aligned to MEM_DEPTH*4
//
// Ports
//   hclk       in   bus clock, all state on rising edge
//   hresetn    in   asynchronous active-low reset
//   hsel       in   slave select from the address decoder
//   hready_in  in   bus-level HREADY (previous transfer complete)
//   htrans     in   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite     in   1 = write, 0 = read
//   hsize      in   transfer size (byte/halfword/word)
//   haddr      in   byte address
//   hwdata     in   write data, valid in the data phase
//   hrdata     out  read data, zero outside a read data phase
//   hready     out  data phase completes this cycle
//   hresp      out  00 OKAY, 01 ERROR
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no data phase in progress, ready for an address phase
// WAIT   | OKAY transfer accepted, wait-state counter running down
// DATA   | OKAY data phase completes; write lands at this edge
// ERR1   | first ERROR cycle (hready low)
// ERR2   | second ERROR cycle (hready high), can accept next transfer
// ---------------------------------------------------------------------------
module ahb_slave_ws_mem #(
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic        hready_in,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic [1:0]  hresp
);

    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);
    localparam logic [4:0]  WS_INIT   = 5'(WAIT_STATES);

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    // Elaboration-time sanity checks on the parameter set.
    if ((MEM_DEPTH < 4) || (MEM_DEPTH > 4096) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ahb_slave_ws_mem: MEM_DEPTH must be a power of two in 4..4096");
    end
    if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_ws
        $error("ahb_slave_ws_mem: WAIT_STATES must be in 0..15");
    end
    if ((BASE_ADDR % MEM_BYTES) != 0) begin : g_bad_base
        $error("ahb_slave_ws_mem: BASE_ADDR must be aligned to MEM_DEPTH*4");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [4:0]       ws_cnt;
    logic [4:0]       ws_cnt_nxt;

    // Address-phase attributes held for the data phase.
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lane_q;
    logic [2:0]       size_q;
    logic             write_q;

    logic [31:0]      mem [MEM_DEPTH];

    logic [31:0]      offset;
    logic             can_accept;
    logic             accept;
    logic             addr_ok;
    logic             size_ok;
    logic             align_ok;
    logic             xfer_ok;
    logic             accept_ok;
    logic             accept_err;
    logic [3:0]       byte_en;
    logic             mem_we;

    // -----------------------------------------------------------------------
    // Address-phase decode
    // -----------------------------------------------------------------------
    // Subtracting the base first makes addresses below BASE_ADDR wrap to a
    // huge offset, so one unsigned compare covers both ends of the window.
    assign offset  = haddr - BASE_ADDR;
    assign addr_ok = (offset < MEM_BYTES);

    // Only states that drive hready high may take a new address phase.
    assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept     = can_accept && hsel && hready_in && htrans[1];

    // BASE_ADDR is aligned, so alignment can be judged on haddr directly.
    always_comb begin
        size_ok  = 1'b1;
        align_ok = 1'b1;
        case (hsize)
            SIZE_BYTE: align_ok = 1'b1;
            SIZE_HALF: align_ok = ~haddr[0];
            SIZE_WORD: align_ok = (haddr[1:0] == 2'b00);
            default:   size_ok  = 1'b0;
        endcase
    end

    assign xfer_ok    = addr_ok && size_ok && align_ok;
    assign accept_ok  = accept && xfer_ok;
    assign accept_err = accept && !xfer_ok;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state  <= ST_IDLE;
            ws_cnt <= 5'd0;
        end else begin
            state  <= state_nxt;
            ws_cnt <= ws_cnt_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        ws_cnt_nxt = ws_cnt;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_nxt  = ST_IDLE;
                ws_cnt_nxt = 5'd0;
                if (accept_err) begin
                    state_nxt = ST_ERR1;
                end else if (accept_ok) begin
                    if (WS_INIT != 5'd0) begin
                        state_nxt  = ST_WAIT;
                        ws_cnt_nxt = WS_INIT;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                // Counter loads WAIT_STATES and leaves on terminal count 1,
                // giving exactly WAIT_STATES cycles in this state.
                if (ws_cnt <= 5'd1) begin
                    state_nxt  = ST_DATA;
                    ws_cnt_nxt = 5'd0;
                end else begin
                    ws_cnt_nxt = ws_cnt - 5'd1;
                end
            end
            ST_ERR1: begin
                state_nxt = ST_ERR2;
            end
            default: begin
                state_nxt  = ST_IDLE;
                ws_cnt_nxt = 5'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        hready = 1'b1;
        hresp  = RESP_OKAY;
        hrdata = 32'h0;
        case (state)
            ST_WAIT: begin
                hready = 1'b0;
            end
            ST_DATA: begin
                if (!write_q) begin
                    hrdata = mem[idx_q];
                end
            end
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = RESP_ERROR;
            end
            ST_ERR2: begin
                hresp = RESP_ERROR;
            end
            default: begin
                hready = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Address-phase capture
    // -----------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            idx_q   <= '0;
            lane_q  <= 2'b00;
            size_q  <= SIZE_BYTE;
            write_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= offset[IDX_W+1:2];
            lane_q  <= haddr[1:0];
            size_q  <= hsize;
            write_q <= hwrite;
        end
    end

    // -----------------------------------------------------------------------
    // Memory write path (little-endian byte lanes)
    // -----------------------------------------------------------------------
    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            SIZE_BYTE: byte_en = 4'b0001 << lane_q;
            SIZE_HALF: byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: byte_en = 4'b1111;
            default:   byte_en = 4'b0000;
        endcase
    end

    // Only OKAY transfers reach DATA, so errored writes never get here.
    assign mem_we = (state == ST_DATA) && write_q;

    // Storage is deliberately left without reset.
    always_ff @(posedge hclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule
